// File: rtl/ram_pkg.sv
// Shared encodings for the dual-port RAM: write-mode selectors and controller states.
package ram_pkg;

    localparam int WRITE_MODE_NO_CHANGE = 0;
    localparam int WRITE_MODE_THROUGH   = 1;

    typedef enum logic {
        STATE_CLEAR = 1'b0,
        STATE_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/ram_read_pipe.sv
// Read-return pipeline for one RAM port: captures the array read, plus an optional second stage.
// Data registers only load on a valid beat, so outputs hold their last value between reads.
module ram_read_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_dat_i,
    input  logic                  in_vld_i,
    output logic [DATA_WIDTH-1:0] out_dat_o,
    output logic                  out_vld_o
);

    logic [DATA_WIDTH-1:0] s1_dat_q;
    logic                  s1_vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_dat_q <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= in_vld_i;
            if (in_vld_i) begin
                s1_dat_q <= in_dat_i;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_stage2
            logic [DATA_WIDTH-1:0] s2_dat_q;
            logic                  s2_vld_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s2_dat_q <= '0;
                    s2_vld_q <= 1'b0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        s2_dat_q <= s1_dat_q;
                    end
                end
            end

            assign out_dat_o = s2_dat_q;
            assign out_vld_o = s2_vld_q;
        end else begin : g_stage1
            assign out_dat_o = s1_dat_q;
            assign out_vld_o = s1_vld_q;
        end
    endgenerate

endmodule

// File: rtl/ram_dual_port.sv
// Dual-port block RAM: port A read/write, port B read-only, optional zero-fill after reset.
// Requests arriving while busy are dropped; reads are read-first against a same-cycle port A write.
module ram_dual_port
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    WRITE_MODE     = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    input  logic                  a_write_enable,
    input  logic                  a_read_enable,
    output logic [DATA_WIDTH-1:0] a_data_out,
    output logic                  a_data_valid,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic                  b_read_enable,
    output logic [DATA_WIDTH-1:0] b_data_out,
    output logic                  b_data_valid,
    output logic                  busy
);

    localparam int              DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam state_e          RESET_STATE = (CLEAR_ON_RESET != 0) ? STATE_CLEAR : STATE_RUN;
    localparam logic            WR_THROUGH  = (WRITE_MODE == WRITE_MODE_THROUGH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
    logic                  clr_we;

    logic                  a_wr, a_rd, b_rd;
    logic [DATA_WIDTH-1:0] a_s0_dat, b_s0_dat;
    logic                  a_s0_vld, b_s0_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            STATE_CLEAR: begin
                clr_cnt_d = clr_cnt_q + (ADDR_WIDTH + 1)'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = STATE_RUN;
                end
            end
            STATE_RUN: begin
                state_d = STATE_RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == STATE_CLEAR);
        clr_we = (state_q == STATE_CLEAR);
    end

    assign a_wr = a_write_enable & ~busy;
    assign a_rd = a_read_enable  & ~busy;
    assign b_rd = b_read_enable  & ~busy;

    // A write takes priority over a read on port A; its response follows WRITE_MODE.
    assign a_s0_vld = a_wr ? WR_THROUGH : a_rd;
    assign a_s0_dat = a_wr ? a_data_in : mem[a_address];
    assign b_s0_vld = b_rd;
    assign b_s0_dat = mem[b_address];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
        end else if (a_wr) begin
            mem[a_address] <= a_data_in;
        end
    end

    ram_read_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_dat_i  (a_s0_dat),
        .in_vld_i  (a_s0_vld),
        .out_dat_o (a_data_out),
        .out_vld_o (a_data_valid)
    );

    ram_read_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_dat_i  (b_s0_dat),
        .in_vld_i  (b_s0_vld),
        .out_dat_o (b_data_out),
        .out_vld_o (b_data_valid)
    );

endmodule

// File: tb/tb_ram_dual_port.sv
// Directed bench: dut0 is latency 1 / no-change, dut1 is latency 2 / write-through; both 16 words.
module tb_ram_dual_port;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;

    logic [AW-1:0] a_addr0, b_addr0, a_addr1, b_addr1;
    logic [DW-1:0] a_din0, a_din1;
    logic          a_we0, a_re0, b_re0, a_we1, a_re1, b_re1;
    logic [DW-1:0] a_dout0, b_dout0, a_dout1, b_dout1;
    logic          a_vld0, b_vld0, a_vld1, b_vld1;
    logic          busy0, busy1;

    int            checks = 0;
    int            errors = 0;
    int            cycles;
    logic          seen;
    logic [DW-1:0] vals [3];

    ram_dual_port #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_MODE(0),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_addr0), .a_data_in(a_din0), .a_write_enable(a_we0),
        .a_read_enable(a_re0), .a_data_out(a_dout0), .a_data_valid(a_vld0),
        .b_address(b_addr0), .b_read_enable(b_re0), .b_data_out(b_dout0),
        .b_data_valid(b_vld0), .busy(busy0)
    );

    ram_dual_port #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_MODE(1),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_addr1), .a_data_in(a_din1), .a_write_enable(a_we1),
        .a_read_enable(a_re1), .a_data_out(a_dout1), .a_data_valid(a_vld1),
        .b_address(b_addr1), .b_read_enable(b_re1), .b_data_out(b_dout1),
        .b_data_valid(b_vld1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_we0 = 1'b0; a_re0 = 1'b0; b_re0 = 1'b0;
        a_we1 = 1'b0; a_re1 = 1'b0; b_re1 = 1'b0;
    endtask

    initial begin
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30;
        reset_n = 1'b0;
        idle();
        a_addr0 = '0; b_addr0 = '0; a_addr1 = '0; b_addr1 = '0;
        a_din0  = '0; a_din1  = '0;
        repeat (3) tick();

        chk("rst_busy0", busy0, 1);
        chk("rst_busy1", busy1, 1);
        chk("rst_a_vld", a_vld0, 0);
        chk("rst_a_dat", a_dout0, 0);
        chk("rst_b_dat", b_dout1, 0);

        // Clear sequence, with a dropped write/read burst injected mid-way
        reset_n = 1'b1;
        cycles  = 0;
        seen    = 1'b0;
        while (busy0 && cycles < 100) begin
            if (cycles == 3) begin
                a_we0 = 1'b1; a_re0 = 1'b1; a_addr0 = 4'd2; a_din0 = 8'hFF;
                b_re0 = 1'b1; b_addr0 = 4'd2;
                a_we1 = 1'b1; a_re1 = 1'b1; a_addr1 = 4'd2; a_din1 = 8'hFF;
                b_re1 = 1'b1; b_addr1 = 4'd2;
            end else begin
                idle();
            end
            tick();
            cycles++;
            seen = seen | a_vld0 | b_vld0 | a_vld1 | b_vld1;
        end
        idle();
        chk("clr_cycles", cycles, 16);
        chk("clr_no_vld", seen, 0);
        chk("clr_busy1", busy1, 0);

        for (int i = 0; i < 16; i++) begin
            a_re0 = 1'b1; a_addr0 = 4'(i);
            b_re0 = 1'b1; b_addr0 = 4'(15 - i);
            tick();
            chk("zero_a_vld", a_vld0, 1);
            chk("zero_a_dat", a_dout0, 0);
            chk("zero_b_vld", b_vld0, 1);
            chk("zero_b_dat", b_dout0, 0);
        end
        idle();
        tick();
        chk("rd_vld_drop", a_vld0, 0);

        a_we0 = 1'b1; a_addr0 = 4'd3; a_din0 = 8'hA5;
        tick();
        chk("wr_no_vld", a_vld0, 0);
        a_we0 = 1'b0; a_re0 = 1'b1;
        tick();
        chk("rd3_vld", a_vld0, 1);
        chk("rd3_dat", a_dout0, 8'hA5);
        a_re0 = 1'b0;
        tick();
        chk("hold_vld", a_vld0, 0);
        chk("hold_dat", a_dout0, 8'hA5);

        a_we0 = 1'b1; a_re0 = 1'b1; a_addr0 = 4'd6; a_din0 = 8'h33;
        tick();
        chk("rw_no_vld", a_vld0, 0);
        chk("rw_hold", a_dout0, 8'hA5);
        a_we0 = 1'b0;
        tick();
        chk("rd6_dat", a_dout0, 8'h33);
        a_re0 = 1'b0;

        a_we0 = 1'b1; a_addr0 = 4'd5; a_din0 = 8'h11;
        tick();
        a_din0 = 8'h22; b_re0 = 1'b1; b_addr0 = 4'd5;
        tick();
        chk("coll_b_vld", b_vld0, 1);
        chk("coll_b_old", b_dout0, 8'h11);
        a_we0 = 1'b0;
        tick();
        chk("coll_b_new", b_dout0, 8'h22);
        b_re0 = 1'b0;
        tick();

        // Latency-2 write-through on port A, then latency-2 reads on port B
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                a_we1 = 1'b1; a_addr1 = 4'(c); a_din1 = vals[c];
            end else begin
                a_we1 = 1'b0;
            end
            tick();
            chk("wt_vld", a_vld1, (c >= 1 && c <= 3));
            if (c >= 1 && c <= 3) chk("wt_dat", a_dout1, vals[c-1]);
        end
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                b_re1 = 1'b1; b_addr1 = 4'(c);
            end else begin
                b_re1 = 1'b0;
            end
            tick();
            chk("rl2_vld", b_vld1, (c >= 1 && c <= 3));
            if (c >= 1 && c <= 3) chk("rl2_dat", b_dout1, vals[c-1]);
        end
        chk("rl2_hold", b_dout1, 8'h30);

        reset_n = 1'b0;
        #2;
        chk("arst_a_dat", a_dout0, 0);
        chk("arst_b_dat", b_dout0, 0);
        chk("arst_b1_dat", b_dout1, 0);
        chk("arst_busy", busy0, 1);
        tick();
        reset_n = 1'b1;
        repeat (7) tick();
        chk("mid_busy", busy0, 1);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_busy", busy0, 1);
        chk("mid_rst_vld", a_vld0, 0);
        #1;
        reset_n = 1'b1;
        cycles = 0;
        while (busy0 && cycles < 100) begin
            tick();
            cycles++;
        end
        chk("clr2_cycles", cycles, 16);

        a_re0 = 1'b1; a_addr0 = 4'd5; b_re0 = 1'b1; b_addr0 = 4'd3;
        tick();
        idle();
        chk("clr2_a_vld", a_vld0, 1);
        chk("clr2_a5", a_dout0, 0);
        chk("clr2_b3", b_dout0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
